uart_tx_ctrl: RTL

Parametrised UART transmit controller. It combines frame sequencing, LSB-first serialisation, even/odd parity generation, one or two stop bits and a per-bit clock prescaler in a single registered block. It accepts a parallel word on a `Data_Valid` strobe and drives the serial line `TX_OUT`. It is the next-generation replacement for the fixed-width 8N1/8P1 transmit FSM + mux arrangement and sits between the register/FIFO front end and the pad.

---
 rtl/uart_tx_ctrl_if.sv | 31 +++
 rtl/uart_tx_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Transmit-side bundle between the register/FIFO front end and uart_tx_ctrl.
// The front end is the master and the transmit controller is the slave.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  // Handshake: a frame is accepted on a rising clk edge where Data_Valid=1 and
  // the controller is free, meaning Busy=0 or the last stop cycle is ending.
  // Data_Valid seen while Busy=1 at any other time is dropped. The controller
  // never queues a request.
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_En;
  logic                  Par_Typ;
  logic                  Stop_Two;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  TX_OUT;
  logic                  Busy;
  logic                  Done;
  logic [2:0]            dbg_state;

  modport master (
    output P_DATA, Data_Valid, Par_En, Par_Typ, Stop_Two, Prescale,
    input  TX_OUT, Busy, Done, dbg_state
  );

  modport slave (
    input  P_DATA, Data_Valid, Par_En, Par_Typ, Stop_Two, Prescale,
    output TX_OUT, Busy, Done, dbg_state
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, LSB-first data, optional parity, and one
// or two stop bits. Each bit lasts a prescaled number of clk cycles.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic          clk,
  input logic          RST,
  uart_tx_ctrl_if.slave bus
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_n;
  logic [PRESCALE_W-1:0] timer_q, timer_n;
  logic [PRESCALE_W-1:0] presc_q, presc_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic                  stop_half_q, stop_half_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  par_en_q, par_en_n;
  logic                  parity_q, parity_n;
  logic                  stop_two_q, stop_two_n;
  logic                  tx_q, tx_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;

  logic [PRESCALE_W-1:0] presc_eff;
  logic                  bit_end;
  logic                  frame_end;
  logic                  accept;

  always_comb begin
    presc_eff = (bus.Prescale == '0) ? PRESCALE_W'(1) : bus.Prescale;
    bit_end   = (timer_q == (presc_q - PRESCALE_W'(1)));
    // The stop phase ends on the last bit_end of its one or two stop slots.
    frame_end = (state_q == STOP) && bit_end && (!stop_two_q || stop_half_q);
    // A frame that finishes on this edge frees the controller for a new request.
    accept    = bus.Data_Valid && ((state_q == IDLE) || frame_end);
  end

  always_comb begin
    state_n     = state_q;
    timer_n     = timer_q;
    presc_n     = presc_q;
    idx_n       = idx_q;
    stop_half_n = stop_half_q;
    data_n      = data_q;
    par_en_n    = par_en_q;
    parity_n    = parity_q;
    stop_two_n  = stop_two_q;
    tx_n        = tx_q;
    busy_n      = busy_q;
    done_n      = 1'b0;

    if (state_q == IDLE) begin
      timer_n = '0;
    end else if (bit_end) begin
      timer_n = '0;
    end else begin
      timer_n = timer_q + PRESCALE_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_n = PARITY;
              tx_n    = parity_q;
            end else begin
              state_n     = STOP;
              stop_half_n = 1'b0;
              tx_n        = 1'b1;
            end
          end else begin
            idx_n = idx_q + IDX_W'(1);
            tx_n  = data_q[idx_q + IDX_W'(1)];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n     = STOP;
          stop_half_n = 1'b0;
          tx_n        = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_two_q && !stop_half_q) begin
            stop_half_n = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // Accept overrides the frame-end return to IDLE, giving gapless back-to-back frames.
    if (accept) begin
      state_n     = START;
      timer_n     = '0;
      idx_n       = '0;
      stop_half_n = 1'b0;
      presc_n     = presc_eff;
      data_n      = bus.P_DATA;
      par_en_n    = bus.Par_En;
      parity_n    = (^bus.P_DATA) ^ bus.Par_Typ;
      stop_two_n  = bus.Stop_Two;
      tx_n        = 1'b0;
      busy_n      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      stop_half_q <= 1'b0;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      parity_q    <= 1'b0;
      stop_two_q  <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      timer_q     <= timer_n;
      presc_q     <= presc_n;
      idx_q       <= idx_n;
      stop_half_q <= stop_half_n;
      data_q      <= data_n;
      par_en_q    <= par_en_n;
      parity_q    <= parity_n;
      stop_two_q  <= stop_two_n;
      tx_q        <= tx_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
    end
  end

  assign bus.TX_OUT    = tx_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.dbg_state = state_q;
endmodule
